serial_tx_arbiter: RTL and testbench

- Shares the single serial transmitter between up to four byte requesters, e.g. push-button/DIP-switch entry, RX echo, and status reporting.
- Selects one requester by round-robin, latches its byte and starts the transmitter.
- Waits for frame completion, then enforces an inter-frame idle gap before the next grant.
- Sits between the board I/O logic and the transmitter inside the lab top level.

---
 rtl/serial_tx_arbiter_pkg.sv | 21 ++
 rtl/serial_tx_arbiter_rr.sv | 14 +
 rtl/serial_tx_arbiter.sv | 73 +++++++
 tb/tb_serial_tx_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/serial_tx_arbiter_pkg.sv
// serial_tx_arbiter_pkg: shared state encoding, UART timing defaults and sizing helper
package serial_tx_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } arb_state_t;
  localparam int DEF_CLK_HZ = 50_000_000;
  localparam int DEF_BAUD = 9600;
  localparam int DEF_BIT_CYCLES = DEF_CLK_HZ / DEF_BAUD;
  localparam int DEF_GAP_CYCLES = DEF_BIT_CYCLES;
  localparam int DEF_TIMEOUT_CYCLES = 1_000_000;
  // Never returns 0 so a counter sized for a count of 1 still has a bit
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/serial_tx_arbiter_rr.sv
// rr_select4: combinational round-robin pick of the first request at or after ptr
module rr_select4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] sel
);
  logic [3:0] rot;
  logic [1:0] off;
  assign rot = 4'({req, req} >> ptr);
  assign off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
  assign valid = |req;
  assign sel = ptr + off;
endmodule

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin sharing of one serial transmitter among four byte requesters
module serial_tx_arbiter
  import serial_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               M_CLOCK,
  input  logic               RESET,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   grant,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_busy,
  input  logic               tx_done,
  output logic               timeout_err,
  output logic [1:0]         active_id
);
  localparam int WD_W = clog2(TIMEOUT_CYCLES);
  localparam int GAP_W = clog2(GAP_CYCLES);
  arb_state_t state, state_nxt;
  logic [1:0] rr_ptr, sel;
  logic valid, take, wd_exp, gap_end;
  logic [WD_W-1:0] wd;
  logic [GAP_W-1:0] gap_cnt;
  logic unused_busy;
  assign unused_busy = tx_busy;
  rr_select4 u_rr (
    .req(req),
    .ptr(rr_ptr),
    .valid(valid),
    .sel(sel)
  );
  assign take = (state == IDLE) && valid;
  assign wd_exp = wd == WD_W'(TIMEOUT_CYCLES - 1);
  assign gap_end = gap_cnt == GAP_W'(GAP_CYCLES - 1);
  always_comb begin
    state_nxt = take ? LAUNCH :
                (state == LAUNCH) ? WAIT_DONE :
                (state == WAIT_DONE && (tx_done || wd_exp)) ? GAP :
                (state == GAP && gap_end) ? IDLE : state;
  end
  always_ff @(posedge M_CLOCK) begin
    if (RESET) state <= IDLE;
    else state <= state_nxt;
  end
  // tx_start is registered so it trails grant by exactly one cycle
  always_ff @(posedge M_CLOCK) begin
    if (RESET) begin
      grant <= '0;
      tx_start <= 1'b0;
      tx_data <= '0;
      timeout_err <= 1'b0;
      active_id <= '0;
      rr_ptr <= '0;
      wd <= '0;
      gap_cnt <= '0;
    end else begin
      grant <= take ? N_REQ'(1) << sel : '0;
      tx_start <= state == LAUNCH;
      if (take) begin
        tx_data <= req_data[8*sel +: 8];
        active_id <= sel;
      end
      if (state == LAUNCH) rr_ptr <= active_id + 2'd1;
      wd <= (state == WAIT_DONE) ? wd + WD_W'(1) : '0;
      if (state == WAIT_DONE && wd_exp && !tx_done) timeout_err <= 1'b1;
      gap_cnt <= (state == GAP && !gap_end) ? gap_cnt + GAP_W'(1) : '0;
    end
  end
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter: directed checks of grant order, latency, gap, watchdog and reset
module tb_serial_tx_arbiter;
  localparam int G_B = 5208;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_a = '0, req_b = '0, grant_a, grant_b;
  logic [31:0] data_a = 32'h4433_2211;
  logic [31:0] data_b = 32'hC3A5_5A3C;
  logic tx_start_a, tx_start_b, terr_a, terr_b;
  logic [7:0] tx_data_a, tx_data_b;
  logic [1:0] aid_a, aid_b;
  logic busy = 1'b0, done_a = 1'b0, done_b = 1'b0;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  serial_tx_arbiter #(.GAP_CYCLES(4), .TIMEOUT_CYCLES(50)) u_a (
    .M_CLOCK(clk), .RESET(rst), .req(req_a), .req_data(data_a), .grant(grant_a),
    .tx_start(tx_start_a), .tx_data(tx_data_a), .tx_busy(busy), .tx_done(done_a),
    .timeout_err(terr_a), .active_id(aid_a)
  );
  serial_tx_arbiter u_b (
    .M_CLOCK(clk), .RESET(rst), .req(req_b), .req_data(data_b), .grant(grant_b),
    .tx_start(tx_start_b), .tx_data(tx_data_b), .tx_busy(busy), .tx_done(done_b),
    .timeout_err(terr_b), .active_id(aid_b)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_grant(output logic [3:0] g);
    int n;
    n = 0;
    while (grant_a == 4'b0 && n < 20) begin
      tick;
      n++;
    end
    g = grant_a;
  endtask
  initial begin
    #500_000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end
  initial begin
    logic [3:0] g;
    int bad;
    logic [3:0] rr_exp [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b1000};
    logic [1:0] rr_id [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3};
    logic [7:0] rr_byte [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h44};
    repeat (3) tick;
    check("rst_grant", grant_a, 0);
    check("rst_start", tx_start_a, 0);
    check("rst_data", tx_data_a, 0);
    check("rst_terr", terr_a, 0);
    check("rst_aid", aid_a, 0);
    check("rst_grant_b", grant_b, 0);
    rst = 1'b0;
    // single request on the default-parameter instance
    req_b = 4'b0100;
    tick;
    check("b_grant", grant_b, 4'b0100);
    check("b_data", tx_data_b, 8'hA5);
    check("b_aid", aid_b, 2);
    check("b_start_early", tx_start_b, 0);
    req_b = 4'b0001;
    tick;
    check("b_start", tx_start_b, 1);
    bad = 0;
    for (int c = 1; c <= 101 + G_B; c++) begin
      tick;
      done_b = (c == 100);
      if (grant_b !== 4'b0 || tx_start_b !== 1'b0) bad++;
    end
    done_b = 1'b0;
    check("b_quiet", bad, 0);
    tick;
    check("b_next", grant_b, 4'b0001);
    check("b_terr", terr_b, 0);
    req_b = '0;
    // spurious tx_done in IDLE
    done_a = 1'b1;
    tick;
    done_a = 1'b0;
    check("sp_start", tx_start_a, 0);
    check("sp_grant", grant_a, 0);
    check("sp_terr", terr_a, 0);
    // round-robin then wrap with 1001
    req_a = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      wait_grant(g);
      check("rr_grant", g, rr_exp[k]);
      check("rr_aid", aid_a, rr_id[k]);
      check("rr_data", tx_data_a, rr_byte[k]);
      if (k == 3) req_a = 4'b1001;
      tick;
      check("rr_start", tx_start_a, 1);
      done_a = 1'b1;
      tick;
      done_a = 1'b0;
    end
    req_a = '0;
    // watchdog abort
    req_a = 4'b0100;
    wait_grant(g);
    check("to_grant", g, 4'b0100);
    req_a = '0;
    tick;
    repeat (49) tick;
    check("to_early", terr_a, 0);
    tick;
    check("to_set", terr_a, 1);
    req_a = 4'b0010;
    repeat (4) tick;
    check("to_gap", grant_a, 0);
    tick;
    check("to_next", grant_a, 4'b0010);
    req_a = '0;
    tick;
    done_a = 1'b1;
    tick;
    done_a = 1'b0;
    check("to_sticky", terr_a, 1);
    // reset in WAIT_DONE
    req_a = 4'b0100;
    wait_grant(g);
    check("rm_grant_pre", g, 4'b0100);
    req_a = '0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    check("rm_grant", grant_a, 0);
    check("rm_start", tx_start_a, 0);
    check("rm_data", tx_data_a, 0);
    check("rm_terr", terr_a, 0);
    check("rm_aid", aid_a, 0);
    rst = 1'b0;
    req_a = 4'b1010;
    tick;
    check("rm_ptr_grant", grant_a, 4'b0010);
    check("rm_ptr_aid", aid_a, 1);
    req_a = '0;
    tick;
    check("rm_start_after", tx_start_a, 1);
    // tx_done on the last watchdog cycle wins
    repeat (48) tick;
    tick;
    done_a = 1'b1;
    tick;
    done_a = 1'b0;
    check("co_terr", terr_a, 0);
    req_a = 4'b0001;
    wait_grant(g);
    check("co_next", g, 4'b0001);
    req_a = '0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
